// File: rtl/el_add_buf.sv
// el_add_buf: dual-rail, level-encoded (2-phase) adder with a result FIFO.
// A complete input token on links A, B and C is summed, pushed into the FIFO
// and acknowledged. The FIFO head is then sent through a dual-rail output
// register whenever the sum and carry receivers have both acknowledged the
// previous output.
// Optional build macro: EL_ADD_BUF_SYNC_EN adds 2-flop synchronisers on
// in_a, in_b, in_c, ack_s_i and ack_c_i.
module el_add_buf #(
    parameter int WIDTH    = 8,
    parameter int DEPTH    = 4,
    parameter int RAIL_NUM = 2
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [RAIL_NUM*WIDTH-1:0]  in_a,
    output logic                       ack_a_o,
    input  logic [RAIL_NUM*WIDTH-1:0]  in_b,
    output logic                       ack_b_o,
    input  logic [RAIL_NUM-1:0]        in_c,
    output logic                       ack_c_o,
    output logic [RAIL_NUM*WIDTH-1:0]  out_s,
    input  logic                       ack_s_i,
    output logic [RAIL_NUM-1:0]        out_c,
    input  logic                       ack_c_i,
    output logic [$clog2(DEPTH+1)-1:0] level
);
    localparam int LW = $clog2(DEPTH+1);
    localparam int PW = $clog2(DEPTH);
    localparam logic [LW-1:0] FULL_LEVEL = LW'(DEPTH);

    logic [RAIL_NUM*WIDTH-1:0] w_a;
    logic [RAIL_NUM*WIDTH-1:0] w_b;
    logic [RAIL_NUM-1:0]       w_c;
    logic                      w_ackS;
    logic                      w_ackC;

`ifdef EL_ADD_BUF_SYNC_EN
    logic [RAIL_NUM*WIDTH-1:0] r_aMeta;
    logic [RAIL_NUM*WIDTH-1:0] r_aSync;
    logic [RAIL_NUM*WIDTH-1:0] r_bMeta;
    logic [RAIL_NUM*WIDTH-1:0] r_bSync;
    logic [RAIL_NUM-1:0]       r_cMeta;
    logic [RAIL_NUM-1:0]       r_cSync;
    logic [1:0]                r_ackMeta;
    logic [1:0]                r_ackSync;

    // Two-flop synchronisers for every input coming from another timing domain
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_aMeta   <= '0;
            r_aSync   <= '0;
            r_bMeta   <= '0;
            r_bSync   <= '0;
            r_cMeta   <= '0;
            r_cSync   <= '0;
            r_ackMeta <= '0;
            r_ackSync <= '0;
        end else begin
            r_aMeta   <= in_a;
            r_aSync   <= r_aMeta;
            r_bMeta   <= in_b;
            r_bSync   <= r_bMeta;
            r_cMeta   <= in_c;
            r_cSync   <= r_cMeta;
            r_ackMeta <= {ack_s_i, ack_c_i};
            r_ackSync <= r_ackMeta;
        end
    end

    assign w_a    = r_aSync;
    assign w_b    = r_bSync;
    assign w_c    = r_cSync;
    assign w_ackS = r_ackSync[1];
    assign w_ackC = r_ackSync[0];
`else
    assign w_a    = in_a;
    assign w_b    = in_b;
    assign w_c    = in_c;
    assign w_ackS = ack_s_i;
    assign w_ackC = ack_c_i;
`endif

    logic             r_inPh;
    logic             r_outPh;
    logic [LW-1:0]    r_level;
    logic [PW-1:0]    r_wrPtr;
    logic [PW-1:0]    r_rdPtr;
    logic [WIDTH:0]   r_outVal;
    logic [WIDTH:0]   r_mem [DEPTH];

    logic [WIDTH-1:0] w_aVal;
    logic [WIDTH-1:0] w_bVal;
    logic             w_cVal;
    logic             w_complete;
    logic [WIDTH:0]   w_sum;
    logic             w_push;
    logic             w_pop;
    logic             w_linkIdle;

    // Recover operand values and detect a token whose every bit has moved to the new phase
    always_comb begin
        w_complete = 1'b1;
        w_aVal     = '0;
        w_bVal     = '0;
        for (int i = 0; i < WIDTH; i++) begin
            w_aVal[i] = w_a[RAIL_NUM*i+1];
            w_bVal[i] = w_b[RAIL_NUM*i+1];
            if ((w_a[RAIL_NUM*i+1] ^ w_a[RAIL_NUM*i]) == r_inPh) begin
                w_complete = 1'b0;
            end
            if ((w_b[RAIL_NUM*i+1] ^ w_b[RAIL_NUM*i]) == r_inPh) begin
                w_complete = 1'b0;
            end
        end
        w_cVal = w_c[1];
        if ((w_c[1] ^ w_c[0]) == r_inPh) begin
            w_complete = 1'b0;
        end
    end

    assign w_sum      = {1'b0, w_aVal} + {1'b0, w_bVal} + {{WIDTH{1'b0}}, w_cVal};
    assign w_push     = w_complete && (r_level != FULL_LEVEL);
    assign w_linkIdle = (w_ackS == r_outPh) && (w_ackC == r_outPh);
    assign w_pop      = w_linkIdle && (r_level != '0);

    // Handshake phases, FIFO pointers/occupancy and the output register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_inPh   <= 1'b0;
            r_outPh  <= 1'b0;
            r_level  <= '0;
            r_wrPtr  <= '0;
            r_rdPtr  <= '0;
            r_outVal <= '0;
        end else begin
            if (w_push) begin
                r_inPh  <= ~r_inPh;
                r_wrPtr <= r_wrPtr + PW'(1);
            end
            if (w_pop) begin
                r_outPh  <= ~r_outPh;
                r_outVal <= r_mem[r_rdPtr];
                r_rdPtr  <= r_rdPtr + PW'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_level <= r_level + LW'(1);
                2'b01:   r_level <= r_level - LW'(1);
                default: r_level <= r_level;
            endcase
        end
    end

    // FIFO storage needs no reset because the pointers define what is valid
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wrPtr] <= w_sum;
        end
    end

    // Re-encode the held result as dual-rail with the current output phase
    always_comb begin
        out_s = '0;
        for (int i = 0; i < WIDTH; i++) begin
            out_s[RAIL_NUM*i+1] = r_outVal[i];
            out_s[RAIL_NUM*i]   = r_outVal[i] ^ r_outPh;
        end
        out_c = {r_outVal[WIDTH], r_outVal[WIDTH] ^ r_outPh};
    end

    assign ack_a_o = r_inPh;
    assign ack_b_o = r_inPh;
    assign ack_c_o = r_inPh;
    assign level   = r_level;

endmodule

// File: doc/el_add_buf.md
EL_ADD_BUF -- requirements
Module: el_add_buf

Interface
REQ-001 Parameter WIDTH, default 8, operand width in bits, 1..32.
REQ-002 Parameter DEPTH, default 4, result FIFO entries, power of 2, >=2.
REQ-003 Parameter RAIL_NUM, default 2, rails per bit, fixed at 2.
REQ-004 clk  in  1  single clock; all state updates on the rising edge.
REQ-005 rst  in  1  reset, asynchronous assert, active-low (0 = reset).
REQ-006 in_a  in  2*WIDTH  operand A; bit i on rails [2i+1:2i].
REQ-007 ack_a_o  out  1  2-phase ack for link A.
REQ-008 in_b  in  2*WIDTH  operand B; same encoding as in_a.
REQ-009 ack_b_o  out  1  2-phase ack for link B.
REQ-010 in_c  in  2  carry-in, one dual-rail bit.
REQ-011 ack_c_o  out  1  2-phase ack for link C.
REQ-012 out_s  out  2*WIDTH  sum, dual-rail.
REQ-013 ack_s_i  in  1  2-phase ack from the sum receiver.
REQ-014 out_c  out  2  carry-out, one dual-rail bit.
REQ-015 ack_c_i  in  1  2-phase ack from the carry receiver.
REQ-016 level  out  $clog2(DEPTH+1)  current FIFO occupancy.

Function
REQ-017 Encoding per bit: level-encoded dual-rail; value = rail[1], phase = rail[1]^rail[0].
REQ-018 Internal input phase in_ph; token complete when every bit of in_a, in_b, in_c has phase != in_ph.
REQ-019 Mixed phases across bits (partial arrival): no accept, no state change.
REQ-020 Accept: complete and level<DEPTH at an edge -> push {A+B+Cin} (WIDTH+1 bits, MSB = carry) and toggle in_ph.
REQ-021 ack_a_o = ack_b_o = ack_c_o = in_ph register; ack toggles 1 cycle after the inputs are sampled complete.
REQ-022 Full (level==DEPTH): inputs held unacknowledged; a pop at the same edge does not admit a push; the push occurs at the next edge at the earliest.
REQ-023 Output phase out_ph; the link is idle when ack_s_i==out_ph and ack_c_i==out_ph.
REQ-024 Send: link idle and level>0 -> pop the head, load the output register, toggle out_ph; out_s[2i+1]=sum_i, out_s[2i]=sum_i^out_ph; out_c likewise.
REQ-025 A single ack of the two (s or c) leaves the link busy; the next send waits for both.
REQ-026 Latency from inputs complete to output transition with an empty FIFO and an idle link: 2 cycles.
REQ-027 Push and pop at the same edge with 0<level<DEPTH: level unchanged; data order preserved (FIFO).
REQ-028 Throughput: 1 token per cycle when the receiver acks within 1 cycle.

Reset
REQ-029 rst low: in_ph=0, out_ph=0, FIFO empty, level=0, all ack outputs 0, out_s and out_c all rails 0 (value 0, phase 0).
REQ-030 Reset mid-operation discards FIFO contents and any in-flight token; after release, inputs whose phase is still 1 are treated as a new token.

Configuration
REQ-031 Macro EL_ADD_BUF_SYNC_EN defined: in_a, in_b, in_c, ack_s_i and ack_c_i pass through 2-flop synchronisers (reset to 0) before use; REQ-026 latency becomes 4 cycles and REQ-021 ack delay becomes 3 cycles.
REQ-032 Macro undefined: inputs are used directly and are required to be synchronous to clk.

Verification (WIDTH=8, DEPTH=4, macro undefined)
REQ-033 A=0x7F, B=0x01, Cin=0, all tokens phase 1 -> out_s value 0x80, out_c 0, phase 1, two cycles later; acks go to 1.
REQ-034 A=0xFF, B=0x01, Cin=1 -> sum 0x01, carry 1; ack_s_i toggles while ack_c_i is held -> no further send until ack_c_i toggles.
REQ-035 Toggle only A bits 0..6 plus B and C -> no ack and level stays 0; toggle A bit 7 -> accept on the next edge.
REQ-036 Acks held, 6 tokens offered -> 5 accepted (1 in the output register + 4 in the FIFO), level=4, 6th unacked; one ack pair -> 6th accepted, results in order.
REQ-037 rst pulsed low with level=3 -> level=0, outputs all-zero rails, acks 0 immediately (asynchronous).
REQ-038 Macro defined, repeat REQ-033 -> output transition at 4 cycles, ack at 3 cycles.
